// File: rtl/sobel_frame_ctrl_if.sv
// Pixel-side bus of the sobel frame sequencer: upstream source, pipeline feed,
// pipeline return and downstream output. Signal suffixes are from the controller's view.
interface sobel_frame_ctrl_if;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_pixel_i;
  logic       pipe_reset_o;
  logic       pipe_valid_o;
  logic [7:0] pipe_pixel_o;
  logic       pipe_valid_i;
  logic [7:0] pipe_pixel_i;
  logic       out_valid_o;
  logic [7:0] out_pixel_o;

  modport slave (
    input  in_valid_i, in_pixel_i, pipe_valid_i, pipe_pixel_i,
    output in_ready_o, pipe_reset_o, pipe_valid_o, pipe_pixel_o,
    output out_valid_o, out_pixel_o
  );

  modport master (
    output in_valid_i, in_pixel_i, pipe_valid_i, pipe_pixel_i,
    input  in_ready_o, pipe_reset_o, pipe_valid_o, pipe_pixel_o,
    input  out_valid_o, out_pixel_o
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the sobel pipeline: clear, admit one frame, drain, signal done.
// Optional SOBEL_FRAME_CYCLE_CNT_EN adds frame_cycles_o (STREAM+DRAIN cycle count).
module sobel_frame_ctrl #(
  parameter int WIDTH_P         = 10,
  parameter int HEIGHT_P        = 10,
  parameter int CLEAR_CYCLES_P  = 2,
  parameter int DRAIN_TIMEOUT_P = 64
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
`ifdef SOBEL_FRAME_CYCLE_CNT_EN
  output logic [31:0] frame_cycles_o,
`endif
  sobel_frame_ctrl_if.slave px
);
  localparam int N     = WIDTH_P * HEIGHT_P;
  localparam int CNT_W = $clog2(N + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES_P + 1);
  localparam int DRN_W = $clog2(DRAIN_TIMEOUT_P + 1);
  localparam logic [CNT_W-1:0] N_C      = CNT_W'(N);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES_P - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT_P - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             err_q, err_d;

  logic             active;
  logic             hs;
  logic             fwd;
  logic [CNT_W-1:0] out_cnt_beat;

  assign active = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign hs     = px.in_valid_i && (state_q == S_STREAM);
  assign fwd    = px.pipe_valid_i && active;

  assign px.in_ready_o   = (state_q == S_STREAM);
  assign px.pipe_valid_o = hs;
  assign px.pipe_pixel_o = px.in_pixel_i;
  assign px.pipe_reset_o = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign px.out_valid_o  = fwd;
  assign px.out_pixel_o  = px.pipe_pixel_i;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign err_o  = err_q;

  // Output count including this cycle's beat; saturates so stray beats are not counted.
  assign out_cnt_beat = (fwd && (out_cnt_q != N_C)) ? out_cnt_q + 1'b1 : out_cnt_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    if (abort_i && (state_q == S_CLEAR || active)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            err_d     = 1'b0;
          end
        end
        S_CLEAR: begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == CLR_LAST) state_d = S_STREAM;
        end
        S_STREAM: begin
          if (hs) in_cnt_d = in_cnt_q + 1'b1;
          out_cnt_d = out_cnt_beat;
          if (hs && (in_cnt_q == N_LAST)) begin
            if (out_cnt_beat == N_C) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_DRAIN;
              drain_cnt_d = '0;
            end
          end
        end
        S_DRAIN: begin
          out_cnt_d   = out_cnt_beat;
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (out_cnt_beat == N_C) begin
            state_d = S_DONE;
          end else if (drain_cnt_q == DRN_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef SOBEL_FRAME_CYCLE_CNT_EN
  logic [31:0] fc_q, fc_d;
  logic [31:0] fc_lat_q, fc_lat_d;

  // The latch takes fc_d so the cycle that moves into DONE is itself counted.
  always_comb begin
    fc_d     = fc_q;
    fc_lat_d = fc_lat_q;
    if (state_q == S_IDLE && state_d == S_CLEAR) begin
      fc_d = '0;
    end else if (active && (fc_q != 32'hFFFF_FFFF)) begin
      fc_d = fc_q + 32'd1;
    end
    if (state_d == S_DONE && state_q != S_DONE) fc_lat_d = fc_d;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      fc_q     <= '0;
      fc_lat_q <= '0;
    end else begin
      fc_q     <= fc_d;
      fc_lat_q <= fc_lat_d;
    end
  end

  assign frame_cycles_o = fc_lat_q;
`endif
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomized bench for sobel_frame_ctrl: per-cycle compare against a behavioural
// model, a delay-line stand-in for the sobel pipeline, and literal per-frame checks.
module tb_sobel_frame_ctrl;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int CL  = 2;
  localparam int TO  = 64;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, busy, done, err;
`ifdef SOBEL_FRAME_CYCLE_CNT_EN
  logic [31:0] fcyc;
`endif

  sobel_frame_ctrl_if bus();

  sobel_frame_ctrl #(.WIDTH_P(W), .HEIGHT_P(H), .CLEAR_CYCLES_P(CL), .DRAIN_TIMEOUT_P(TO)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err),
`ifdef SOBEL_FRAME_CYCLE_CNT_EN
    .frame_cycles_o(fcyc),
`endif
    .px(bus.slave)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the frame sequence
  typedef enum int {M_IDLE, M_CLEAR, M_STREAM, M_DRAIN, M_DONE} mph_e;
  mph_e   ms = M_IDLE;
  int     m_in = 0, m_out = 0, m_clr = 0, m_drn = 0;
  bit     m_err = 0;
  longint m_fc = 0, m_fco = 0;

  // Pipeline stand-in: fixed W+1 latency, optional output limit, optional stray pulses
  bit         dl_v[LAT];
  logic [7:0] dl_p[LAT];
  int         emitted = 0, emit_limit = 1000;
  bit         stray = 0;

  // Per-frame statistics taken from DUT outputs
  int st_hs, st_beats, st_after, st_done, st_clr, st_drn;
  bit all_in_prev, last_done;

  task automatic clear_stats();
    st_hs = 0; st_beats = 0; st_after = 0; st_done = 0; st_clr = 0; st_drn = 0;
    all_in_prev = 0;
  endtask

  task automatic step();
    bit         pv;
    logic [7:0] pp;
    bit         m_hs, m_ov, act;
    pv = (dl_v[LAT-1] && emitted < emit_limit) || stray;
    pp = stray ? 8'($urandom) : (dl_p[LAT-1] ^ 8'hA5);
    bus.pipe_valid_i = pv;
    bus.pipe_pixel_i = pp;
    @(negedge clk);
    act  = (ms == M_STREAM) || (ms == M_DRAIN);
    m_hs = bus.in_valid_i && (ms == M_STREAM);
    m_ov = pv && act;
    chk("busy", busy, ms != M_IDLE);
    chk("done", done, ms == M_DONE);
    chk("err", err, m_err);
    chk("in_ready", bus.in_ready_o, ms == M_STREAM);
    chk("pipe_valid", bus.pipe_valid_o, m_hs);
    chk("pipe_reset", bus.pipe_reset_o, (ms == M_IDLE) || (ms == M_CLEAR));
    chk("out_valid", bus.out_valid_o, m_ov);
    if (m_hs) chk("pipe_pixel", bus.pipe_pixel_o, bus.in_pixel_i);
    if (m_ov) chk("out_pixel", bus.out_pixel_o, pp);
`ifdef SOBEL_FRAME_CYCLE_CNT_EN
    chk("frame_cycles", fcyc, m_fco[31:0]);
`endif
    // statistics from what the DUT actually did
    st_hs    += int'(bus.in_valid_i && bus.in_ready_o);
    st_beats += int'(bus.out_valid_o);
    if (bus.out_valid_o && all_in_prev) st_after++;
    all_in_prev = (st_hs >= N);
    st_done  += int'(done);
    if (busy && bus.pipe_reset_o) st_clr++;
    if (busy && !bus.pipe_reset_o && !bus.in_ready_o && !done) st_drn++;
    last_done = done;
    // model next state
    if (!rst_n) begin
      ms = M_IDLE; m_in = 0; m_out = 0; m_clr = 0; m_drn = 0; m_err = 0; m_fc = 0; m_fco = 0;
    end else if (abort && (ms == M_CLEAR || act)) begin
      ms = M_IDLE;
    end else begin
      case (ms)
        M_IDLE: if (start) begin
          ms = M_CLEAR; m_clr = 0; m_in = 0; m_out = 0; m_err = 0; m_fc = 0;
        end
        M_CLEAR: begin
          m_clr++;
          if (m_clr == CL) ms = M_STREAM;
        end
        M_STREAM, M_DRAIN: begin
          if (m_fc < 64'hFFFF_FFFF) m_fc++;
          if (m_ov && m_out < N) m_out++;
          if (ms == M_STREAM) begin
            if (m_hs) begin
              m_in++;
              if (m_in == N) begin
                if (m_out == N) begin ms = M_DONE; m_fco = m_fc; end
                else begin ms = M_DRAIN; m_drn = 0; end
              end
            end
          end else begin
            if (m_out == N) begin ms = M_DONE; m_fco = m_fc; end
            else if (m_drn == TO - 1) begin m_err = 1; ms = M_DONE; m_fco = m_fc; end
            else m_drn++;
          end
        end
        default: ms = M_IDLE;
      endcase
    end
    // pipeline stand-in advances
    if (bus.pipe_reset_o) begin
      for (int i = 0; i < LAT; i++) dl_v[i] = 0;
      emitted = 0;
    end else begin
      if (dl_v[LAT-1] && emitted < emit_limit) emitted++;
      for (int i = LAT - 1; i > 0; i--) begin dl_v[i] = dl_v[i-1]; dl_p[i] = dl_p[i-1]; end
      dl_v[0] = bus.pipe_valid_o;
      dl_p[0] = bus.pipe_pixel_o;
    end
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 = valid held high, 1 = toggling 1,0,1,0, 2 = random
  task automatic run_frame(input int vmode, input int abort_at, input bit rst_drain, input int limit);
    int cyc;
    bit fin;
    emit_limit = limit;
    clear_stats();
    start = 1; bus.in_valid_i = 0; bus.in_pixel_i = 8'($urandom);
    step();
    start = 0;
    fin = 0; cyc = 0;
    while (!fin && cyc < 400) begin
      case (vmode)
        0:       bus.in_valid_i = 1;
        1:       bus.in_valid_i = (cyc % 2 == 0);
        default: bus.in_valid_i = 1'($urandom_range(0, 1));
      endcase
      bus.in_pixel_i = 8'($urandom);
      abort = (abort_at >= 0) && (st_hs >= abort_at) && (ms == M_STREAM);
      rst_n = !(rst_drain && ms == M_DRAIN && m_drn == 2);
      if (abort || !rst_n) fin = 1;
      step();
      if (last_done) fin = 1;
      cyc++;
    end
    abort = 0; rst_n = 1; bus.in_valid_i = 0;
    if (!fin) chk("frame_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid_i = 1'($urandom_range(0, 1));
      bus.in_pixel_i = 8'($urandom);
      step();
    end
    bus.in_valid_i = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0;
    bus.in_valid_i = 0; bus.in_pixel_i = 0; bus.pipe_valid_i = 0; bus.pipe_pixel_i = 0;
    for (int i = 0; i < LAT; i++) begin dl_v[i] = 0; dl_p[i] = 0; end
    @(posedge clk); #1;
    step(); step();
    chk("rst_pipe_reset", bus.pipe_reset_o, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    idle(3);

    // continuous frame
    run_frame(0, -1, 0, 1000);
    chk("A_clear_cycles", st_clr, CL);
    chk("A_handshakes", st_hs, N);
    chk("A_beats", st_beats, N);
    chk("A_beats_after_last_in", st_after, W + 1);
    chk("A_drain_cycles", st_drn, W + 1);
    chk("A_done_pulses", st_done, 1);
    chk("A_err", err, 0);
`ifdef SOBEL_FRAME_CYCLE_CNT_EN
    idle(1);
    chk("A_frame_cycles", fcyc, N + W + 1);
`endif
    idle(3);

    // toggling valid
    run_frame(1, -1, 0, 1000);
    chk("B_handshakes", st_hs, N);
    chk("B_beats", st_beats, N);
    chk("B_done_pulses", st_done, 1);
    idle(2);

    // stalled drain: pipeline stops after 12 outputs
    run_frame(0, -1, 0, 12);
    chk("C_beats", st_beats, 12);
    chk("C_drain_cycles", st_drn, TO);
    chk("C_done_pulses", st_done, 1);
    chk("C_err", err, 1);
    idle(5);
    chk("C_err_sticky", err, 1);
    run_frame(0, -1, 0, 1000);
    chk("C2_err_cleared", err, 0);
    chk("C2_beats", st_beats, N);
    idle(2);

    // abort after 7 accepted inputs, then stray pipeline pulses while idle
    run_frame(0, 7, 0, 1000);
    chk("D_done_pulses", st_done, 0);
    chk("D_pipe_reset", bus.pipe_reset_o, 1);
    chk("D_busy", busy, 0);
    clear_stats();
    stray = 1; idle(3); stray = 0;
    chk("D_stray_beats", st_beats, 0);
    idle(2);

    // reset in the middle of DRAIN, then a clean frame
    run_frame(0, -1, 1, 1000);
    chk("E_done_pulses", st_done, 0);
    idle(1);
    chk("E_busy", busy, 0);
    chk("E_pipe_reset", bus.pipe_reset_o, 1);
    run_frame(0, -1, 0, 1000);
    chk("E2_beats", st_beats, N);
    chk("E2_done_pulses", st_done, 1);
    idle(2);

    // randomized frames, some aborted
    for (int f = 0; f < 6; f++) begin
      run_frame(2, (f % 3 == 2) ? int'($urandom_range(0, N - 1)) : -1, 0, 1000);
      idle(int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
